wb_load_align_q: RTL and testbench

- Parametrised writeback stage between the memory-response side and the register-file write port.
- Buffers load/ALU results in a small request queue and applies MIPS sub-word load alignment: LB/LBU/LH/LHU/LW/LWL/LWR, plus LWU/LD when DATA_W=64.
- Drives one registered register-file write per accepted request.
- Supports backpressure through a valid/ready input handshake and a downstream stall.

---
 rtl/wb_load_align_q.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_wb_load_align_q.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_load_align_q.sv
// ---------------------------------------------------------------------------
// wb_load_align_q
//
// Writeback stage that sits between the memory-response side and the
// register-file write port. Requests (load results or ALU results) are
// buffered in a small circular queue. The queue head is aligned for MIPS
// sub-word loads (LB/LBU/LH/LHU/LW/LWL/LWR, plus LWU/LD when DATA_W=64) and
// is then captured in a single output register. That register drives one
// register-file write per accepted request.
//
// Parameters:
//   DATA_W   datapath width, 32 or 64
//   DEPTH    queue entries, power of two, >= 2
//   RADDR_W  register address width
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready request handshake into the queue
//   in_op             0 PASS,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 LWU,7 LWL,8 LWR,
//                     9 LD; 10-15 are treated as PASS
//   in_alures         ALU result (PASS)
//   in_opr2           old rt value merged by LWL/LWR
//   in_vaddr          virtual address bits [2:0]
//   in_rdata          naturally aligned memory read data
//   in_wreg/in_waddr  request writes register in_waddr
//   wb_stall          hold the output register
//   out_wen/out_waddr/out_wdata  register-file write port
//   q_empty           queue and output register both empty
//
// Optional build macro WB_MISALIGN_EXC_EN:
//   Adds out_adel and out_badlo. A misaligned load then raises out_adel
//   (with out_badlo = vaddr) instead of writing zero, and its write is
//   suppressed.
//
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on the queue's registered
// full state, so it never depends combinationally on in_valid. A full queue
// that is popping in the same cycle still reports in_ready=0.
// ---------------------------------------------------------------------------
module wb_load_align_q #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [DATA_W-1:0]  in_alures,
    input  logic [DATA_W-1:0]  in_opr2,
    input  logic [2:0]         in_vaddr,
    input  logic [DATA_W-1:0]  in_rdata,
    input  logic               in_wreg,
    input  logic [RADDR_W-1:0] in_waddr,
    input  logic               wb_stall,
    output logic               out_wen,
    output logic [RADDR_W-1:0] out_waddr,
    output logic [DATA_W-1:0]  out_wdata,
    output logic               q_empty
`ifdef WB_MISALIGN_EXC_EN
    ,
    output logic               out_adel,
    output logic [2:0]         out_badlo
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam bit IS64  = (DATA_W == 64);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_LWU = 4'd6;
    localparam logic [3:0] OP_LWL = 4'd7;
    localparam logic [3:0] OP_LWR = 4'd8;
    localparam logic [3:0] OP_LD  = 4'd9;

    typedef struct packed {
        logic [3:0]         op;
        logic [DATA_W-1:0]  alures;
        logic [DATA_W-1:0]  opr2;
        logic [2:0]         vaddr;
        logic [DATA_W-1:0]  rdata;
        logic               wreg;
        logic [RADDR_W-1:0] waddr;
    } entry_t;

    // ------------------------------------------------------------------
    // Queue state
    // ------------------------------------------------------------------
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    // Output register state
    logic               out_vld_q,   out_vld_d;
    logic               out_wreg_q,  out_wreg_d;
    logic [RADDR_W-1:0] out_waddr_q, out_waddr_d;
    logic [DATA_W-1:0]  out_wdata_q, out_wdata_d;
    logic               out_adel_q,  out_adel_d;
    logic [2:0]         out_badlo_q, out_badlo_d;

    logic   q_full;
    logic   q_emp;
    logic   push;
    logic   pop;
    entry_t in_entry;
    entry_t head;

    // Pointers carry one extra wrap bit: equal indices with differing wrap
    // bits means full, identical pointers means empty.
    assign q_full = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign q_emp  = (wr_ptr_q == rd_ptr_q);

    assign push = in_valid && !q_full;
    // The head moves into the output register whenever that register is
    // free or is being drained this cycle.
    assign pop  = !q_emp && (!out_vld_q || !wb_stall);

    assign in_entry = '{op: in_op, alures: in_alures, opr2: in_opr2,
                        vaddr: in_vaddr, rdata: in_rdata, wreg: in_wreg,
                        waddr: in_waddr};
    assign head = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = in_entry;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Load alignment on the queue head (little-endian byte lanes)
    // ------------------------------------------------------------------
    logic [2:0]        byte_idx;
    logic [1:0]        lane;
    logic [7:0]        b8;
    logic [15:0]       h16;
    logic [31:0]       w32;
    logic [31:0]       o32;
    logic [31:0]       merged;
    logic              misaligned;
    logic [DATA_W-1:0] align_data;

    always_comb begin
        // A 32-bit datapath only has four byte lanes, so vaddr[2] is ignored.
        byte_idx   = IS64 ? head.vaddr : {1'b0, head.vaddr[1:0]};
        lane       = head.vaddr[1:0];
        b8         = 8'(head.rdata >> {byte_idx, 3'b000});
        h16        = 16'(head.rdata >> {byte_idx[2:1], 4'b0000});
        w32        = 32'(head.rdata >> {(IS64 ? head.vaddr[2] : 1'b0), 5'b00000});
        o32        = 32'(head.opr2);
        merged     = w32;
        misaligned = 1'b0;
        align_data = head.alures;

        case (head.op)
            OP_LB:  align_data = DATA_W'($signed(b8));
            OP_LBU: align_data = DATA_W'(b8);
            OP_LH: begin
                misaligned = head.vaddr[0];
                align_data = DATA_W'($signed(h16));
            end
            OP_LHU: begin
                misaligned = head.vaddr[0];
                align_data = DATA_W'(h16);
            end
            OP_LW: begin
                misaligned = (lane != 2'b00);
                align_data = DATA_W'($signed(w32));
            end
            OP_LWU: begin
                misaligned = (lane != 2'b00);
                if (IS64) begin
                    align_data = DATA_W'(w32);
                end else begin
                    align_data = DATA_W'($signed(w32));
                end
            end
            OP_LD: begin
                // On a 32-bit datapath LD is a plain word load, so only word
                // alignment matters there.
                if (IS64) begin
                    misaligned = (head.vaddr != 3'd0);
                    align_data = head.rdata;
                end else begin
                    misaligned = (lane != 2'b00);
                    align_data = DATA_W'($signed(w32));
                end
            end
            OP_LWL: begin
                case (lane)
                    2'd0:    merged = {w32[7:0],  o32[23:0]};
                    2'd1:    merged = {w32[15:0], o32[15:0]};
                    2'd2:    merged = {w32[23:0], o32[7:0]};
                    default: merged = w32;
                endcase
                align_data = DATA_W'($signed(merged));
            end
            OP_LWR: begin
                case (lane)
                    2'd0:    merged = w32;
                    2'd1:    merged = {o32[31:24], w32[31:8]};
                    2'd2:    merged = {o32[31:16], w32[31:16]};
                    default: merged = {o32[31:8],  w32[31:24]};
                endcase
                align_data = DATA_W'($signed(merged));
            end
            default: align_data = head.alures;
        endcase

        if (misaligned) begin
            align_data = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_comb begin
        out_vld_d   = out_vld_q;
        out_wreg_d  = out_wreg_q;
        out_waddr_d = out_waddr_q;
        out_wdata_d = out_wdata_q;
        out_adel_d  = out_adel_q;
        out_badlo_d = out_badlo_q;
        if (pop) begin
            out_vld_d   = 1'b1;
            out_wreg_d  = head.wreg;
            out_waddr_d = head.waddr;
            out_wdata_d = align_data;
            out_adel_d  = misaligned;
            out_badlo_d = misaligned ? head.vaddr : 3'd0;
        end else if (!wb_stall) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_vld_q   <= 1'b0;
            out_wreg_q  <= 1'b0;
            out_waddr_q <= '0;
            out_wdata_q <= '0;
            out_adel_q  <= 1'b0;
            out_badlo_q <= 3'd0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_vld_q   <= out_vld_d;
            out_wreg_q  <= out_wreg_d;
            out_waddr_q <= out_waddr_d;
            out_wdata_q <= out_wdata_d;
            out_adel_q  <= out_adel_d;
            out_badlo_q <= out_badlo_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = !q_full;
    assign q_empty   = q_emp && !out_vld_q;
    assign out_waddr = out_waddr_q;
    assign out_wdata = out_wdata_q;

`ifdef WB_MISALIGN_EXC_EN
    // A faulting load reports through out_adel and never writes the regfile.
    assign out_wen   = out_vld_q && out_wreg_q && !out_adel_q && !wb_stall && !rst;
    assign out_adel  = out_vld_q && out_adel_q && !wb_stall && !rst;
    assign out_badlo = out_badlo_q;
`else
    // Without the exception ports a misaligned load simply writes zero, and
    // the captured flag and address go unused.
    assign out_wen   = out_vld_q && out_wreg_q && !wb_stall && !rst;
    logic unused_exc;
    assign unused_exc = out_adel_q ^ (^out_badlo_q);
`endif

endmodule

// File: tb/tb_wb_load_align_q.sv
module tb_wb_load_align_q;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_LWU  = 4'd6;
    localparam logic [3:0] OP_LWL  = 4'd7;
    localparam logic [3:0] OP_LWR  = 4'd8;
    localparam logic [3:0] OP_LD   = 4'd9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic        in_valid = 1'b0;
    logic [3:0]  in_op    = 4'd0;
    logic [63:0] in_alures = '0;
    logic [63:0] in_opr2   = '0;
    logic [2:0]  in_vaddr  = 3'd0;
    logic [63:0] in_rdata  = '0;
    logic        in_wreg   = 1'b0;
    logic [4:0]  in_waddr  = 5'd0;
    logic        wb_stall  = 1'b0;

    // ---------------- DUT outputs ----------------
    logic        rdy32, wen32, qe32;
    logic [4:0]  waddr32;
    logic [31:0] wdata32;
    logic        rdy64, wen64, qe64;
    logic [4:0]  waddr64;
    logic [63:0] wdata64;
`ifdef WB_MISALIGN_EXC_EN
    logic        adel32, adel64;
    logic [2:0]  badlo32, badlo64;
`endif

    wb_load_align_q #(.DATA_W(32), .DEPTH(2), .RADDR_W(5)) u32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy32),
        .in_op(in_op), .in_alures(in_alures[31:0]), .in_opr2(in_opr2[31:0]),
        .in_vaddr(in_vaddr), .in_rdata(in_rdata[31:0]),
        .in_wreg(in_wreg), .in_waddr(in_waddr),
        .wb_stall(wb_stall),
        .out_wen(wen32), .out_waddr(waddr32), .out_wdata(wdata32),
        .q_empty(qe32)
`ifdef WB_MISALIGN_EXC_EN
        , .out_adel(adel32), .out_badlo(badlo32)
`endif
    );

    wb_load_align_q #(.DATA_W(64), .DEPTH(2), .RADDR_W(5)) u64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy64),
        .in_op(in_op), .in_alures(in_alures), .in_opr2(in_opr2),
        .in_vaddr(in_vaddr), .in_rdata(in_rdata),
        .in_wreg(in_wreg), .in_waddr(in_waddr),
        .wb_stall(wb_stall),
        .out_wen(wen64), .out_waddr(waddr64), .out_wdata(wdata64),
        .q_empty(qe64)
`ifdef WB_MISALIGN_EXC_EN
        , .out_adel(adel64), .out_badlo(badlo64)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  op;
        logic [2:0]  vaddr;
        logic [63:0] opr2;
        logic [63:0] rdata;
        logic [63:0] alures;
        bit          is64;
        bit          mis;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] op, input logic [2:0] va,
                                input logic [63:0] opr2, input logic [63:0] rdata,
                                input logic [63:0] alures, input bit is64,
                                input bit mis, input logic [63:0] exp);
        vec_t v;
        v.op = op; v.vaddr = va; v.opr2 = opr2; v.rdata = rdata;
        v.alures = alures; v.is64 = is64; v.mis = mis; v.exp = exp;
        vecs.push_back(v);
    endfunction

    // drives one request for a single cycle on the falling edge
    task automatic drive_req(input logic [3:0] op, input logic [2:0] va,
                             input logic [63:0] opr2, input logic [63:0] rdata,
                             input logic [63:0] alures, input logic [4:0] wa);
        in_valid  = 1'b1;
        in_op     = op;
        in_vaddr  = va;
        in_opr2   = opr2;
        in_rdata  = rdata;
        in_alures = alures;
        in_wreg   = 1'b1;
        in_waddr  = wa;
    endtask

    task automatic fill_stalled(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        @(negedge clk);
        wb_stall = 1'b1;
        drive_req(OP_PASS, 3'd0, '0, '0, a, 5'd1);
        @(negedge clk);
        drive_req(OP_PASS, 3'd0, '0, '0, b, 5'd2);
        @(negedge clk);
        drive_req(OP_PASS, 3'd0, '0, '0, c, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] r64;
        logic [63:0] o64;
        int wr_seen;

        // ---------- 32-bit vectors ----------
        add(OP_LB,  3'd1, '0, 64'h1234_80FF, '0, 0, 0, 64'hFFFF_FF80);
        add(OP_LBU, 3'd1, '0, 64'h1234_80FF, '0, 0, 0, 64'h0000_0080);
        add(OP_LB,  3'd3, '0, 64'h1234_80FF, '0, 0, 0, 64'h0000_0012);
        add(OP_LB,  3'd0, '0, 64'h1234_80FF, '0, 0, 0, 64'hFFFF_FFFF);
        add(OP_LH,  3'd2, '0, 64'h8001_7FFF, '0, 0, 0, 64'hFFFF_8001);
        add(OP_LHU, 3'd2, '0, 64'h8001_7FFF, '0, 0, 0, 64'h0000_8001);
        add(OP_LH,  3'd0, '0, 64'h8001_7FFF, '0, 0, 0, 64'h0000_7FFF);
        add(OP_LH,  3'd1, '0, 64'h8001_7FFF, '0, 0, 1, 64'h0000_0000);
        add(OP_LW,  3'd0, '0, 64'hDEAD_BEEF, '0, 0, 0, 64'hDEAD_BEEF);
        add(OP_LW,  3'd2, '0, 64'hDEAD_BEEF, '0, 0, 1, 64'h0000_0000);
        add(OP_LWU, 3'd0, '0, 64'h8000_0001, '0, 0, 0, 64'h8000_0001);
        add(OP_LWR, 3'd2, 64'hAABB_CCDD, 64'h1122_3344, '0, 0, 0, 64'hAABB_1122);
        add(OP_LWR, 3'd0, 64'hAABB_CCDD, 64'h1122_3344, '0, 0, 0, 64'h1122_3344);
        add(OP_LWR, 3'd1, 64'hAABB_CCDD, 64'h1122_3344, '0, 0, 0, 64'hAA11_2233);
        add(OP_LWR, 3'd3, 64'hAABB_CCDD, 64'h1122_3344, '0, 0, 0, 64'hAABB_CC11);
        add(OP_LWL, 3'd0, 64'hAABB_CCDD, 64'h1122_3344, '0, 0, 0, 64'h44BB_CCDD);
        add(OP_LWL, 3'd1, 64'hAABB_CCDD, 64'h1122_3344, '0, 0, 0, 64'h3344_CCDD);
        add(OP_LWL, 3'd2, 64'hAABB_CCDD, 64'h1122_3344, '0, 0, 0, 64'h2233_44DD);
        add(OP_LWL, 3'd3, 64'hAABB_CCDD, 64'h1122_3344, '0, 0, 0, 64'h1122_3344);
        add(OP_PASS, 3'd3, '0, 64'hFFFF_FFFF, 64'h0BAD_F00D, 0, 0, 64'h0BAD_F00D);
        add(4'd12,  3'd1, '0, 64'hFFFF_FFFF, 64'h1357_9BDF, 0, 0, 64'h1357_9BDF);
        add(OP_LD,  3'd0, '0, 64'hCAFE_0001, '0, 0, 0, 64'hCAFE_0001);
        // ---------- 64-bit vectors ----------
        r64 = 64'h8765_4321_0000_0001;
        o64 = 64'h0000_0000_AABB_CCDD;
        add(OP_LWU, 3'd4, o64, r64, '0, 1, 0, 64'h0000_0000_8765_4321);
        add(OP_LD,  3'd0, o64, r64, '0, 1, 0, 64'h8765_4321_0000_0001);
        add(OP_LW,  3'd4, o64, r64, '0, 1, 0, 64'hFFFF_FFFF_8765_4321);
        add(OP_LW,  3'd0, o64, r64, '0, 1, 0, 64'h0000_0000_0000_0001);
        add(OP_LB,  3'd7, o64, r64, '0, 1, 0, 64'hFFFF_FFFF_FFFF_FF87);
        add(OP_LBU, 3'd5, o64, r64, '0, 1, 0, 64'h0000_0000_0000_0043);
        add(OP_LH,  3'd6, o64, r64, '0, 1, 0, 64'hFFFF_FFFF_FFFF_8765);
        add(OP_LWL, 3'd4, o64, r64, '0, 1, 0, 64'h0000_0000_21BB_CCDD);
        add(OP_LWR, 3'd5, o64, r64, '0, 1, 0, 64'hFFFF_FFFF_AA87_6543);
        add(OP_LD,  3'd4, o64, r64, '0, 1, 1, 64'h0000_0000_0000_0000);
        add(OP_PASS, 3'd0, o64, r64, 64'h0123_4567_89AB_CDEF, 1, 0, 64'h0123_4567_89AB_CDEF);

        // ---------- reset state ----------
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst in_ready32", {63'd0, rdy32}, 64'd1);
        check("rst q_empty32",  {63'd0, qe32},  64'd1);
        check("rst out_wen32",  {63'd0, wen32}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst in_ready32", {63'd0, rdy32}, 64'd1);
        check("post-rst q_empty32",  {63'd0, qe32},  64'd1);
        check("post-rst out_wdata32", {32'd0, wdata32}, 64'd0);
        check("post-rst waddr32", {59'd0, waddr32}, 64'd0);
        check("post-rst in_ready64", {63'd0, rdy64}, 64'd1);
        check("post-rst q_empty64",  {63'd0, qe64},  64'd1);
        check("post-rst out_wdata64", wdata64, 64'd0);

        // ---------- table-driven vectors ----------
        for (int i = 0; i < vecs.size(); i++) begin
            logic        wen;
            logic [4:0]  wa;
            logic [63:0] wd;
            logic [4:0]  exp_wa;
            exp_wa = 5'(i + 1);
            drive_req(vecs[i].op, vecs[i].vaddr, vecs[i].opr2, vecs[i].rdata,
                      vecs[i].alures, exp_wa);
            @(negedge clk);
            in_valid = 1'b0;
            // accepted at the previous edge, not yet registered
            wen = vecs[i].is64 ? wen64 : wen32;
            check($sformatf("vec%0d early out_wen", i), {63'd0, wen}, 64'd0);
            @(negedge clk);
            wen = vecs[i].is64 ? wen64 : wen32;
            wa  = vecs[i].is64 ? waddr64 : waddr32;
            wd  = vecs[i].is64 ? wdata64 : {32'd0, wdata32};
            check($sformatf("vec%0d out_waddr", i), {59'd0, wa}, {59'd0, exp_wa});
`ifdef WB_MISALIGN_EXC_EN
            begin
                logic       ad;
                logic [2:0] bl;
                ad = vecs[i].is64 ? adel64 : adel32;
                bl = vecs[i].is64 ? badlo64 : badlo32;
                check($sformatf("vec%0d out_adel", i), {63'd0, ad}, {63'd0, vecs[i].mis});
                check($sformatf("vec%0d out_wen", i), {63'd0, wen}, {63'd0, !vecs[i].mis});
                if (vecs[i].mis) begin
                    check($sformatf("vec%0d out_badlo", i), {61'd0, bl}, {61'd0, vecs[i].vaddr});
                end else begin
                    check($sformatf("vec%0d out_wdata", i), wd, vecs[i].exp);
                end
            end
`else
            check($sformatf("vec%0d out_wen", i), {63'd0, wen}, 64'd1);
            check($sformatf("vec%0d out_wdata", i), wd, vecs[i].exp);
`endif
        end

        // ---------- backpressure: stall, fill, release ----------
        @(negedge clk);
        exp_q.push_back(64'h1111_0001);
        exp_q.push_back(64'h2222_0002);
        exp_q.push_back(64'h3333_0003);
        fill_stalled(64'h1111_0001, 64'h2222_0002, 64'h3333_0003);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall%0d in_ready", k), {63'd0, rdy32}, 64'd0);
            check($sformatf("stall%0d out_wen", k),  {63'd0, wen32}, 64'd0);
            check($sformatf("stall%0d out_wdata", k), {32'd0, wdata32}, 64'h1111_0001);
            check($sformatf("stall%0d q_empty", k),  {63'd0, qe32},  64'd0);
            @(negedge clk);
        end
        wb_stall = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check($sformatf("drain%0d out_wen", k),   {63'd0, wen32}, 64'd1);
            check($sformatf("drain%0d out_waddr", k), {59'd0, waddr32}, 64'(k + 1));
            check($sformatf("drain%0d out_wdata", k), {32'd0, wdata32}, e);
            @(negedge clk);
            #1;
        end
        check("drain done out_wen", {63'd0, wen32}, 64'd0);
        check("drain done q_empty", {63'd0, qe32},  64'd1);
        check("drain done queue", 64'(exp_q.size()), 64'd0);

        // ---------- reset while full and stalled ----------
        @(negedge clk);
        fill_stalled(64'h4444_0004, 64'h5555_0005, 64'h6666_0006);
        check("prerst in_ready", {63'd0, rdy32}, 64'd0);
        rst = 1'b1;
        wr_seen = 0;
        #1;
        if (wen32 || wen64) wr_seen++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid-stall rst in_ready32", {63'd0, rdy32}, 64'd1);
        check("mid-stall rst q_empty32",  {63'd0, qe32},  64'd1);
        check("mid-stall rst out_wen32",  {63'd0, wen32}, 64'd0);
        check("mid-stall rst q_empty64",  {63'd0, qe64},  64'd1);
        wb_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (wen32 || wen64) wr_seen++;
            @(negedge clk);
        end
        check("mid-stall rst no writes", 64'(wr_seen), 64'd0);
        check("mid-stall rst stays empty", {63'd0, qe32}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
